mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max bus-wait cycles before abort (range 1..255).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: if_req in 1 fetch request (PC ce); if_addr in 32 fetch address; if_data_o out 32 fetched instruction; if_ready out 1 fetch-done pulse.
REQ-005 SHALL have ports: mem_req in 1 data access request; mem_we in 1 write; mem_sel in 4 byte enables; mem_addr in 32; mem_wdata in 32; mem_rdata_o out 32; mem_ready out 1 data-done pulse.
REQ-006 SHALL have ports: flush in 1 branch taken, cancel outstanding fetch.
REQ-007 SHALL have ports: bus_req out 1; bus_we out 1; bus_sel out 4; bus_addr out 32; bus_wdata out 32; bus_rdata in 32; bus_ack in 1 (single shared memory port).
REQ-008 SHALL have ports: stall_req_if out 1; stall_req_mem out 1; bus_err out 1 timeout pulse.

Function
REQ-009 SHALL implement FSM states IDLE, IF_WAIT, MEM_WAIT, IF_DROP; all bus_* and data outputs registered.
REQ-010 IDLE: mem_req=1 -> MEM_WAIT (data has priority over fetch); else if_req=1 and flush=0 -> IF_WAIT; else stay IDLE.
REQ-011 On leaving IDLE SHALL latch request address/we/sel/wdata onto bus_* and assert bus_req on the next cycle; fetch uses bus_we=0, bus_sel=4'b1111.
REQ-012 bus_* outputs SHALL remain stable while bus_req=1 until the cycle bus_ack=1 is sampled.
REQ-013 MEM_WAIT with bus_ack=1: mem_rdata_o <= bus_rdata (writes: unchanged), mem_ready pulses 1 cycle, bus_req <= 0, -> IDLE.
REQ-014 IF_WAIT with bus_ack=1 and flush=0: if_data_o <= bus_rdata, if_ready pulses 1 cycle, bus_req <= 0, -> IDLE.
REQ-015 IF_WAIT with flush=1 (any cycle, including ack cycle): no if_ready; if ack same cycle -> IDLE, else -> IF_DROP.
REQ-016 IF_DROP: bus_req held until bus_ack, result discarded, -> IDLE; flush in IF_DROP has no effect.
REQ-017 Flush=1 in IDLE SHALL suppress a fetch grant that cycle; mem_req still granted.
REQ-018 At least one IDLE cycle SHALL separate consecutive transactions (grant latency 1 cycle, done pulse no earlier than 2 cycles after request).
REQ-019 stall_req_mem = mem_req & ~mem_ready; stall_req_if = if_req & ~if_ready & ~flush; combinational.
REQ-020 8-bit wait counter SHALL clear on entering any WAIT/DROP state and increment each cycle bus_req=1 without ack.
REQ-021 Counter reaching TIMEOUT_CYC without ack: bus_req <= 0, bus_err pulses 1 cycle, requester's ready pulses with data 0 (IF_DROP: no ready), -> IDLE.
REQ-022 bus_ack sampled in IDLE SHALL be ignored.
REQ-023 Requests SHALL be held by requesters until their ready; requests dropped mid-wait do not cancel the bus transaction.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, bus_req/bus_we=0, bus_sel=0, bus_addr/bus_wdata=0, if_data_o/mem_rdata_o=0, if_ready/mem_ready/bus_err=0, counter=0, independent of clk.
REQ-025 Reset mid-transaction SHALL abandon it; no ready pulse after release; first grant no earlier than first rising edge after rst=1.

Verification
REQ-026 if_req=1, if_addr=0x100, ack 3 cycles after bus_req, bus_rdata=0x00000013 -> bus_addr=0x100, bus_we=0, if_data_o=0x13, single if_ready pulse, stall_req_if high until then.
REQ-027 if_req and mem_req (we=1, sel=0xF, addr=0x2000, wdata=0xDEADBEEF) same cycle -> write issued first, mem_ready, one IDLE cycle, then fetch.
REQ-028 flush 1 cycle after fetch grant, ack 4 cycles later -> no if_ready, bus_req held until ack, IDLE after, next fetch uses new if_addr.
REQ-029 TIMEOUT_CYC=4, mem read, bus_ack never -> bus_req drops after 4 wait cycles, bus_err and mem_ready pulse, mem_rdata_o=0.
REQ-030 rst=0 asserted between clock edges during MEM_WAIT -> bus_req=0 immediately, no mem_ready after release, next request served normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and data access onto one shared bus,
// with fetch cancellation on flush and a bus-wait timeout.
module mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_data_o,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ready,
   input  logic        flush,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall_req_if,
   output logic        stall_req_mem,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT, IF_DROP} state_t;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        bus_req_q, bus_we_q, if_ready_q, mem_ready_q, bus_err_q;
   logic [3:0]  bus_sel_q;
   logic [31:0] bus_addr_q, bus_wdata_q, if_data_q, mem_rdata_q;
   logic        timeout, done;
   assign timeout = !bus_ack && cnt_q == TO_LAST;
   assign done = bus_ack || timeout;
   assign bus_req = bus_req_q;
   assign bus_we = bus_we_q;
   assign bus_sel = bus_sel_q;
   assign bus_addr = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_data_o = if_data_q;
   assign if_ready = if_ready_q;
   assign mem_rdata_o = mem_rdata_q;
   assign mem_ready = mem_ready_q;
   assign bus_err = bus_err_q;
   assign stall_req_mem = mem_req & ~mem_ready_q;
   assign stall_req_if = if_req & ~if_ready_q & ~flush;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
         if (state_q != IDLE && !bus_ack) cnt_q <= cnt_q + 8'd1;
         case (state_q)
            // a requester still sees its own ready pulse this cycle, so it is not re-granted
            IDLE: begin
               if (mem_req && !mem_ready_q) begin
                  state_q     <= MEM_WAIT;
                  cnt_q       <= '0;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= mem_we;
                  bus_sel_q   <= mem_sel;
                  bus_addr_q  <= mem_addr;
                  bus_wdata_q <= mem_wdata;
               end else if (if_req && !flush && !if_ready_q) begin
                  state_q     <= IF_WAIT;
                  cnt_q       <= '0;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_sel_q   <= 4'hF;
                  bus_addr_q  <= if_addr;
                  bus_wdata_q <= '0;
               end
            end
            MEM_WAIT: begin
               if (done) begin
                  state_q     <= IDLE;
                  bus_req_q   <= 1'b0;
                  bus_err_q   <= timeout;
                  mem_ready_q <= 1'b1;
                  if (timeout) mem_rdata_q <= '0;
                  else if (!bus_we_q) mem_rdata_q <= bus_rdata;
               end
            end
            IF_WAIT: begin
               if (done) begin
                  state_q   <= IDLE;
                  bus_req_q <= 1'b0;
                  bus_err_q <= timeout;
                  if (!flush) begin
                     if_ready_q <= 1'b1;
                     if_data_q  <= timeout ? '0 : bus_rdata;
                  end
               end else if (flush) state_q <= IF_DROP;
            end
            IF_DROP: begin
               if (done) begin
                  state_q   <= IDLE;
                  bus_req_q <= 1'b0;
                  bus_err_q <= timeout;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with scoreboard queues checked by a monitor on
// each ready/error pulse; a second instance covers the short timeout.
module tb_mem_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, flush = 1'b0, bus_ack = 1'b0;
   logic        mem_req2 = 1'b0, zero = 1'b0;
   logic [3:0]  mem_sel = '0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
   logic [31:0] if_data_o, mem_rdata_o, bus_addr, bus_wdata;
   logic        if_ready, mem_ready, bus_req, bus_we, stall_req_if, stall_req_mem, bus_err;
   logic [3:0]  bus_sel;
   logic [31:0] if_data2, mem_rdata2, bus_addr2, bus_wdata2;
   logic        if_ready2, mem_ready2, bus_req2, bus_we2, stall_if2, stall_mem2, bus_err2;
   logic [3:0]  bus_sel2;
   int          n_cmp = 0, n_err = 0, err2_pend = 0;
   logic [31:0] q_if[$], q_mem[$], q_mem2[$];

   mem_ctrl dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data_o(if_data_o),
      .if_ready(if_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata_o),
      .mem_ready(mem_ready), .flush(flush), .bus_req(bus_req), .bus_we(bus_we),
      .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
      .bus_err(bus_err)
   );

   mem_ctrl #(.TIMEOUT_CYC(4)) dut2 (
      .clk(clk), .rst(rst), .if_req(zero), .if_addr(if_addr), .if_data_o(if_data2),
      .if_ready(if_ready2), .mem_req(mem_req2), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata2),
      .mem_ready(mem_ready2), .flush(flush), .bus_req(bus_req2), .bus_we(bus_we2),
      .bus_sel(bus_sel2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata),
      .bus_ack(zero), .stall_req_if(stall_if2), .stall_req_mem(stall_mem2),
      .bus_err(bus_err2)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic unexp(string nm, logic [31:0] val);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected pulse (value %h), none required", nm, val);
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic resp(int n, logic [31:0] d);
      repeat (n - 1) tick();
      bus_ack = 1'b1;
      bus_rdata = d;
      tick();
      bus_ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (if_ready) begin
         if (q_if.size() == 0) unexp("sb_if_ready", if_data_o);
         else chk("sb_if_data", if_data_o, q_if.pop_front());
      end
      if (mem_ready) begin
         if (q_mem.size() == 0) unexp("sb_mem_ready", mem_rdata_o);
         else chk("sb_mem_rdata", mem_rdata_o, q_mem.pop_front());
      end
      if (bus_err) unexp("sb_bus_err", 32'd1);
      if (if_ready2) unexp("sb_if_ready2", if_data2);
      if (mem_ready2) begin
         if (q_mem2.size() == 0) unexp("sb_mem_ready2", mem_rdata2);
         else chk("sb_mem_rdata2", mem_rdata2, q_mem2.pop_front());
      end
      if (bus_err2) begin
         if (err2_pend == 0) unexp("sb_bus_err2", 32'd1);
         else begin
            chk("sb_bus_err2", 32'(bus_err2), 32'd1);
            err2_pend--;
         end
      end
   end

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst_ctl", {26'd0, bus_req, bus_we, bus_sel}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_data", if_data_o | mem_rdata_o, 32'd0);
      chk("rst_pulses", {29'd0, if_ready, mem_ready, bus_err}, 32'd0);
      tick(2);
      rst = 1'b1;
      tick();
      // plain fetch, ack three cycles after bus_req
      if_req = 1'b1; if_addr = 32'h100; q_if.push_back(32'h13);
      tick();
      chk("f_bus_req", bus_req, 1); chk("f_bus_addr", bus_addr, 32'h100);
      chk("f_bus_we", bus_we, 0); chk("f_bus_sel", bus_sel, 4'hF);
      chk("f_stall_wait", stall_req_if, 1);
      resp(3, 32'h13);
      chk("f_stall_done", stall_req_if, 0); chk("f_bus_drop", bus_req, 0);
      if_req = 1'b0;
      tick();
      chk("f_single_pulse", if_ready, 0);
      // data read with partial byte enables
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'h3; mem_addr = 32'h40;
      q_mem.push_back(32'hCAFEF00D);
      #1 chk("rd_stall_pend", stall_req_mem, 1);
      tick();
      chk("rd_bus_addr", bus_addr, 32'h40); chk("rd_bus_sel", bus_sel, 4'h3); chk("rd_bus_we", bus_we, 0);
      resp(2, 32'hCAFEF00D);
      chk("rd_stall_done", stall_req_mem, 0);
      mem_req = 1'b0;
      tick();
      // simultaneous write and fetch: write first, one idle cycle, then fetch
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
      if_req = 1'b1; if_addr = 32'h300;
      q_mem.push_back(32'hCAFEF00D); q_if.push_back(32'h12345678);
      tick();
      chk("wr_bus_we", bus_we, 1); chk("wr_bus_addr", bus_addr, 32'h2000);
      chk("wr_bus_wdata", bus_wdata, 32'hDEADBEEF); chk("wr_bus_sel", bus_sel, 4'hF);
      resp(2, 32'hAAAA5555);
      chk("wr_idle_gap", bus_req, 0);
      mem_req = 1'b0; mem_we = 1'b0;
      tick();
      chk("wf_bus_req", bus_req, 1); chk("wf_bus_addr", bus_addr, 32'h300);
      chk("wf_bus_we", bus_we, 0); chk("wf_bus_sel", bus_sel, 4'hF);
      resp(1, 32'h12345678);
      if_req = 1'b0;
      tick();
      // flush one cycle after grant; late ack is discarded
      if_req = 1'b1; if_addr = 32'h500;
      tick();
      chk("fl_bus_addr", bus_addr, 32'h500);
      flush = 1'b1;
      #1 chk("fl_stall", stall_req_if, 0);
      tick();
      flush = 1'b0; if_addr = 32'h600;
      for (int i = 0; i < 3; i++) begin
         chk("fl_hold", bus_req, 1);
         tick();
      end
      bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
      tick();
      bus_ack = 1'b0;
      chk("fl_drop_req", bus_req, 0); chk("fl_no_ready", if_ready, 0);
      q_if.push_back(32'h66);
      tick();
      chk("fl_new_addr", bus_addr, 32'h600);
      resp(1, 32'h66);
      if_req = 1'b0;
      tick();
      // flush in the same cycle as ack
      if_req = 1'b1; if_addr = 32'h700;
      tick(2);
      flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h77;
      tick();
      flush = 1'b0; bus_ack = 1'b0; if_addr = 32'h704;
      chk("fa_no_ready", if_ready, 0); chk("fa_bus_req", bus_req, 0);
      q_if.push_back(32'h704704);
      tick();
      chk("fa_refetch", bus_addr, 32'h704);
      resp(1, 32'h704704);
      if_req = 1'b0;
      tick();
      // flush in idle blocks fetch but not data
      flush = 1'b1; if_req = 1'b1; if_addr = 32'h800;
      tick();
      chk("fi_suppress", bus_req, 0);
      mem_req = 1'b1; mem_addr = 32'h900; mem_sel = 4'hF; q_mem.push_back(32'h99);
      tick();
      flush = 1'b0;
      chk("fi_mem_grant", bus_addr, 32'h900);
      resp(1, 32'h99);
      mem_req = 1'b0; q_if.push_back(32'h88);
      tick();
      chk("fi_fetch_after", bus_addr, 32'h800);
      resp(1, 32'h88);
      if_req = 1'b0;
      tick();
      // ack while idle
      bus_ack = 1'b1; bus_rdata = 32'hDEAD;
      tick(2);
      chk("ai_bus_req", bus_req, 0);
      chk("ai_pulses", {30'd0, if_ready, mem_ready}, 0);
      bus_ack = 1'b0;
      // asynchronous reset during a data wait
      mem_req = 1'b1; mem_addr = 32'hA00;
      tick();
      chk("ar_granted", bus_req, 1);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("ar_bus_req", bus_req, 0); chk("ar_rdata", mem_rdata_o, 0); chk("ar_addr", bus_addr, 0);
      mem_req = 1'b0; bus_ack = 1'b1;
      tick();
      rst = 1'b1;
      tick(2);
      bus_ack = 1'b0;
      chk("ar_no_ready", mem_ready, 0);
      mem_req = 1'b1; mem_addr = 32'hB00; q_mem.push_back(32'hB0B0);
      tick();
      chk("ar_next_addr", bus_addr, 32'hB00);
      resp(2, 32'hB0B0);
      mem_req = 1'b0;
      tick();
      // timeout with TIMEOUT_CYC=4 on the second instance
      mem_addr = 32'hC00; mem_we = 1'b0; bus_rdata = 32'hFFFFFFFF;
      mem_req2 = 1'b1; q_mem2.push_back(32'h0); err2_pend = 1;
      tick();
      chk("to_req", bus_req2, 1); chk("to_addr", bus_addr2, 32'hC00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_hold", bus_req2, 1);
      end
      tick();
      chk("to_drop", bus_req2, 0); chk("to_err", bus_err2, 1);
      chk("to_ready", mem_ready2, 1); chk("to_rdata", mem_rdata2, 0);
      mem_req2 = 1'b0;
      tick(3);
      chk("end_q_if", q_if.size(), 0);
      chk("end_q_mem", q_mem.size(), 0);
      chk("end_q_mem2", q_mem2.size(), 0);
      chk("end_err2", err2_pend, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
